// File: rtl/score_collector_pkg.sv
// -----------------------------------------------------------------------------
// nw_pkg
// Shared types for the alignment score collector: the score and row types, the
// FIFO word that carries a row/score pair, the collector state encoding, the
// most-negative score used as the max-tracking seed, and a saturating row
// increment helper.
// -----------------------------------------------------------------------------
package nw_pkg;

    typedef logic signed [31:0] score_t;
    typedef logic [15:0]        row_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } coll_state_t;

    // One FIFO word: the row the score belongs to and the score itself.
    typedef struct packed {
        row_t   row;
        score_t score;
    } entry_t;

    localparam score_t SCORE_MIN = 32'sh8000_0000;
    localparam row_t   ROW_MAX   = 16'hFFFF;

    // Row counter increment that sticks at the top value instead of wrapping.
    function automatic row_t row_inc_sat(input row_t row);
        if (row == ROW_MAX) begin
            return row;
        end else begin
            return row + 16'd1;
        end
    endfunction

endpackage

// File: rtl/score_collector_if.sv
// -----------------------------------------------------------------------------
// score_collector_if
// Groups the score input strobe from the last-column PE and the per-row output
// stream with its ready handshake.
//   in_valid/in_score/in_finish : score strobe, signed score, finish flag
//   out_valid/out_score/out_row : per-row stream (FIFO head)
//   out_ready                   : downstream accepts the current word
// Modports: master = producer/consumer side (bench or fabric),
//           slave  = the collector.
// -----------------------------------------------------------------------------
interface score_collector_if;
    import nw_pkg::*;

    logic   in_valid;
    score_t in_score;
    logic   in_finish;
    logic   out_ready;
    logic   out_valid;
    score_t out_score;
    row_t   out_row;

    modport master (
        output in_valid, in_score, in_finish, out_ready,
        input  out_valid, out_score, out_row
    );

    modport slave (
        input  in_valid, in_score, in_finish, out_ready,
        output out_valid, out_score, out_row
    );

endinterface

// File: rtl/score_fifo.sv
// -----------------------------------------------------------------------------
// score_fifo
// Synchronous first-word-fall-through FIFO. The head word is visible on o_data
// whenever o_valid is high; a push into a full FIFO is only accepted when a pop
// happens in the same cycle, otherwise the word is dropped and o_drop pulses.
// Ports:
//   clk, reset    : clock, synchronous active-high reset (empties, zeroes RAM)
//   i_clear       : synchronous flush (pointers only)
//   i_push/i_data : write strobe and word
//   i_pop         : remove head word (ignored when empty)
//   o_data        : head word
//   o_valid       : FIFO non-empty
//   o_drop        : push lost because FIFO full with no pop
// Parameters: DEPTH (power of 2, >= 2), T (word type).
// -----------------------------------------------------------------------------
module score_fifo
    import nw_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = entry_t
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_valid,
    output logic o_drop
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_pop;
    logic            w_full;
    logic            w_push;

    // Handshake qualification: a full FIFO still takes a word if it is popping.
    always_comb begin
        w_pop  = i_pop && (r_count != CNT_ZERO);
        w_full = (r_count == FULL_CNT);
        w_push = i_push && (!w_full || w_pop);
        o_drop = i_push && w_full && !w_pop;
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= T'(0);
            end
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
        end else if (i_clear) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != CNT_ZERO);

endmodule

// File: rtl/score_collector.sv
// -----------------------------------------------------------------------------
// score_collector
// Collects the N+1 row scores leaving the last PE column of the alignment
// array, streams them out as {row, score} through a FWFT FIFO and produces an
// alignment summary (final score, and maximum score with its row).
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   arm           : pulse, starts (or restarts) a collection
//   bus (slave)   : score input strobe + per-row output stream
//   result_valid  : summary valid from the first DONE cycle until next arm
//   final_score   : last accepted score
//   max_score/max_row : running maximum and its row
//   busy          : collecting or draining
//   overflow      : sticky, a score was dropped because the FIFO was full
// Parameters: N (last row index), DEPTH (FIFO depth, power of 2, >= 2).
// Build option: SCORE_COLLECTOR_MAX_TRACK_EN enables the signed running-max
// comparator; without it max_score/max_row follow the last accepted score/row.
// -----------------------------------------------------------------------------
module score_collector
    import nw_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    score_collector_if.slave         bus,
    output logic                     result_valid,
    output score_t                   final_score,
    output score_t                   max_score,
    output row_t                     max_row,
    output logic                     busy,
    output logic                     overflow
);

    localparam row_t LAST_ROW = row_t'(N);

    coll_state_t r_state;
    coll_state_t w_next_state;

    row_t        r_row_cnt;
    score_t      r_final_score;
    score_t      r_max_score;
    row_t        r_max_row;
    logic        r_overflow;
    logic        r_result_valid;
    logic        r_busy;

    logic        w_accept;
    logic        w_last_row;
    logic        w_fifo_pop;
    logic        w_fifo_valid;
    logic        w_fifo_drop;
    entry_t      w_fifo_wdata;
    entry_t      w_fifo_rdata;

    // Scores are only taken while collecting; arm in the same cycle aborts the
    // run, so the strobe is discarded rather than pushed into the flushed FIFO.
    always_comb begin
        w_accept     = (r_state == ST_COLLECT) && bus.in_valid && !arm;
        w_last_row   = w_accept && (r_row_cnt == LAST_ROW);
        w_fifo_pop   = w_fifo_valid && bus.out_ready;
        w_fifo_wdata = '{row: r_row_cnt, score: bus.in_score};
    end

    score_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (arm),
        .i_push  (w_accept),
        .i_data  (w_fifo_wdata),
        .i_pop   (w_fifo_pop),
        .o_data  (w_fifo_rdata),
        .o_valid (w_fifo_valid),
        .o_drop  (w_fifo_drop)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: arm restarts from any state; DRAIN waits for the FIFO.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (arm) begin
                    w_next_state = ST_COLLECT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (arm) begin
                    w_next_state = ST_COLLECT;
                end else if (bus.in_finish || w_last_row) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_COLLECT;
                end
            end
            ST_DRAIN: begin
                if (arm) begin
                    w_next_state = ST_COLLECT;
                end else if (!w_fifo_valid) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (arm) begin
                    w_next_state = ST_COLLECT;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Row counter, summary registers and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_cnt      <= 16'd0;
            r_final_score  <= 32'sd0;
            r_max_score    <= SCORE_MIN;
            r_max_row      <= 16'd0;
            r_overflow     <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            if (arm) begin
                r_row_cnt     <= 16'd0;
                r_final_score <= 32'sd0;
                r_max_score   <= SCORE_MIN;
                r_max_row     <= 16'd0;
                r_overflow    <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_row_cnt     <= row_inc_sat(r_row_cnt);
                    r_final_score <= bus.in_score;
`ifdef SCORE_COLLECTOR_MAX_TRACK_EN
                    // Strict compare keeps the earliest row on ties; dropped
                    // words still take part since this runs on every accept.
                    if (bus.in_score > r_max_score) begin
                        r_max_score <= bus.in_score;
                        r_max_row   <= r_row_cnt;
                    end
`else
                    r_max_score <= bus.in_score;
                    r_max_row   <= r_row_cnt;
`endif
                end
                if (w_fifo_drop) begin
                    r_overflow <= 1'b1;
                end
            end
            // Status flags are registered copies of the state being entered.
            r_result_valid <= (w_next_state == ST_DONE);
            r_busy         <= (w_next_state == ST_COLLECT) || (w_next_state == ST_DRAIN);
        end
    end

    assign bus.out_valid = w_fifo_valid;
    assign bus.out_score = w_fifo_rdata.score;
    assign bus.out_row   = w_fifo_rdata.row;

    assign result_valid  = r_result_valid;
    assign final_score   = r_final_score;
    assign max_score     = r_max_score;
    assign max_row       = r_max_row;
    assign busy          = r_busy;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_score_collector.sv
// -----------------------------------------------------------------------------
// tb_score_collector
// Two collectors share one stimulus stream: A (N=3, DEPTH=4) and B (N=4,
// DEPTH=2, so it overflows easily). A queue-based reference model per
// instance predicts every output from the collector's behavioural rules.
// -----------------------------------------------------------------------------
module tb_score_collector;

    localparam int N_A = 3;
    localparam int D_A = 4;
    localparam int N_B = 4;
    localparam int D_B = 2;
    localparam int M_IDLE = 0, M_COLLECT = 1, M_DRAIN = 2, M_DONE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset     = 1'b1;
    logic               arm       = 1'b0;
    logic               in_valid  = 1'b0;
    logic               in_finish = 1'b0;
    logic               out_ready = 1'b0;
    logic signed [31:0] in_score  = 32'sd0;

    logic [1:0]         o_ov, o_rv, o_busy, o_ovf;
    logic signed [31:0] o_sc [2];
    logic signed [31:0] o_fin [2];
    logic signed [31:0] o_max [2];
    logic [15:0]        o_row [2];
    logic [15:0]        o_mrow [2];

    int n_pass  = 0;
    int n_total = 0;

    score_collector_if bus_a ();
    score_collector_if bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_score  = in_score;
    assign bus_a.in_finish = in_finish;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_score  = in_score;
    assign bus_b.in_finish = in_finish;
    assign bus_b.out_ready = out_ready;

    assign o_ov[0]  = bus_a.out_valid;
    assign o_sc[0]  = bus_a.out_score;
    assign o_row[0] = bus_a.out_row;
    assign o_ov[1]  = bus_b.out_valid;
    assign o_sc[1]  = bus_b.out_score;
    assign o_row[1] = bus_b.out_row;

    score_collector #(.N(N_A), .DEPTH(D_A)) dut_a (
        .clk(clk), .reset(reset), .arm(arm), .bus(bus_a.slave),
        .result_valid(o_rv[0]), .final_score(o_fin[0]), .max_score(o_max[0]),
        .max_row(o_mrow[0]), .busy(o_busy[0]), .overflow(o_ovf[0])
    );

    score_collector #(.N(N_B), .DEPTH(D_B)) dut_b (
        .clk(clk), .reset(reset), .arm(arm), .bus(bus_b.slave),
        .result_valid(o_rv[1]), .final_score(o_fin[1]), .max_score(o_max[1]),
        .max_row(o_mrow[1]), .busy(o_busy[1]), .overflow(o_ovf[1])
    );

    // ---------------- reference model ----------------
    int                 m_st [2];
    logic [15:0]        m_row [2];
    logic [15:0]        m_mrow [2];
    logic signed [31:0] m_fin [2];
    logic signed [31:0] m_max [2];
    logic               m_ovf [2];
    logic               m_rv [2];
    logic [47:0]        m_q [2][$];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int   nn;
            int   dd;
            logic pop;
            logic was_empty;
            logic reached;
            nn        = (d == 0) ? N_A : N_B;
            dd        = (d == 0) ? D_A : D_B;
            was_empty = (m_q[d].size() == 0);
            pop       = !was_empty && out_ready;
            reached   = 1'b0;
            if (reset) begin
                m_st[d] = M_IDLE; m_q[d].delete(); m_row[d] = 16'd0; m_fin[d] = 32'sd0;
                m_max[d] = 32'sh80000000; m_mrow[d] = 16'd0; m_ovf[d] = 1'b0; m_rv[d] = 1'b0;
            end else if (arm) begin
                m_st[d] = M_COLLECT; m_q[d].delete(); m_row[d] = 16'd0; m_fin[d] = 32'sd0;
                m_max[d] = 32'sh80000000; m_mrow[d] = 16'd0; m_ovf[d] = 1'b0; m_rv[d] = 1'b0;
            end else begin
                if (pop) void'(m_q[d].pop_front());
                if (m_st[d] == M_COLLECT) begin
                    if (in_valid) begin
                        if (m_q[d].size() < dd) m_q[d].push_back({m_row[d], in_score});
                        else m_ovf[d] = 1'b1;
                        m_fin[d] = in_score;
`ifdef SCORE_COLLECTOR_MAX_TRACK_EN
                        if (in_score > m_max[d]) begin
                            m_max[d]  = in_score;
                            m_mrow[d] = m_row[d];
                        end
`else
                        m_max[d]  = in_score;
                        m_mrow[d] = m_row[d];
`endif
                        reached = (int'(m_row[d]) == nn);
                        if (m_row[d] != 16'hFFFF) m_row[d] = m_row[d] + 16'd1;
                    end
                    if (in_finish || reached) m_st[d] = M_DRAIN;
                end else if (m_st[d] == M_DRAIN && was_empty) begin
                    m_st[d] = M_DONE;
                    m_rv[d] = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            n_total++; if (o_ov[d] !== 1'b0) $display("FAIL reset_out_valid dut%0d got %b want 0", d, o_ov[d]); else n_pass++;
            n_total++; if (o_sc[d] !== 32'sd0) $display("FAIL reset_out_score dut%0d got %0d want 0", d, o_sc[d]); else n_pass++;
            n_total++; if (o_row[d] !== 16'd0) $display("FAIL reset_out_row dut%0d got %0d want 0", d, o_row[d]); else n_pass++;
            n_total++; if (o_rv[d] !== 1'b0) $display("FAIL reset_result_valid dut%0d got %b want 0", d, o_rv[d]); else n_pass++;
            n_total++; if (o_fin[d] !== 32'sd0) $display("FAIL reset_final dut%0d got %0d want 0", d, o_fin[d]); else n_pass++;
            n_total++; if (o_max[d] !== 32'sh80000000) $display("FAIL reset_max dut%0d got %h want 80000000", d, o_max[d]); else n_pass++;
            n_total++; if (o_mrow[d] !== 16'd0) $display("FAIL reset_max_row dut%0d got %0d want 0", d, o_mrow[d]); else n_pass++;
            n_total++; if (o_busy[d] !== 1'b0) $display("FAIL reset_busy dut%0d got %b want 0", d, o_busy[d]); else n_pass++;
            n_total++; if (o_ovf[d] !== 1'b0) $display("FAIL reset_overflow dut%0d got %b want 0", d, o_ovf[d]); else n_pass++;
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic signed [31:0] sc [4];
        sc[0] = -32'sd1; sc[1] = -32'sd2; sc[2] = 32'sd0; sc[3] = 32'sd3;
        out_ready = 1'b1;
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_score = sc[i];
            tick();
            n_total++; if (o_ov[0] !== 1'b1) $display("FAIL basic_valid row%0d got %b want 1", i, o_ov[0]); else n_pass++;
            n_total++; if (o_sc[0] !== sc[i]) $display("FAIL basic_score row%0d got %0d want %0d", i, o_sc[0], sc[i]); else n_pass++;
            n_total++; if (o_row[0] !== 16'(i)) $display("FAIL basic_row got %0d want %0d", o_row[0], i); else n_pass++;
        end
        in_valid = 1'b0;
        tick();
        n_total++; if (o_ov[0] !== 1'b0) $display("FAIL basic_empty got %b want 0", o_ov[0]); else n_pass++;
        n_total++; if (o_rv[0] !== 1'b0 || o_busy[0] !== 1'b1) $display("FAIL basic_drain rv=%b busy=%b want 0 1", o_rv[0], o_busy[0]); else n_pass++;
        tick();
        n_total++; if (o_rv[0] !== 1'b1) $display("FAIL basic_result_valid got %b want 1", o_rv[0]); else n_pass++;
        n_total++; if (o_fin[0] !== 32'sd3) $display("FAIL basic_final got %0d want 3", o_fin[0]); else n_pass++;
        n_total++; if (o_max[0] !== 32'sd3) $display("FAIL basic_max got %0d want 3", o_max[0]); else n_pass++;
        n_total++; if (o_mrow[0] !== 16'd3) $display("FAIL basic_max_row got %0d want 3", o_mrow[0]); else n_pass++;
        n_total++; if (o_busy[0] !== 1'b0) $display("FAIL basic_busy got %b want 0", o_busy[0]); else n_pass++;
    endtask

    task automatic test_stall();
        logic signed [31:0] sc [4];
        logic signed [31:0] exp_max;
        logic [15:0]        exp_row;
        sc[0] = 32'sd5; sc[1] = 32'sd5; sc[2] = 32'sd2; sc[3] = 32'sd1;
`ifdef SCORE_COLLECTOR_MAX_TRACK_EN
        exp_max = 32'sd5; exp_row = 16'd0;
`else
        exp_max = 32'sd1; exp_row = 16'd3;
`endif
        out_ready = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_score = sc[i];
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++; if (o_ov[0] !== 1'b1 || o_sc[0] !== 32'sd5 || o_row[0] !== 16'd0)
                $display("FAIL stall_hold cyc%0d got v=%b s=%0d r=%0d want 1 5 0", k, o_ov[0], o_sc[0], o_row[0]); else n_pass++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (o_sc[0] !== sc[i] || o_row[0] !== 16'(i))
                $display("FAIL stall_pop_word got s=%0d r=%0d want %0d %0d", o_sc[0], o_row[0], sc[i], i); else n_pass++;
            tick();
            n_total++; if (o_rv[0] !== 1'b0) $display("FAIL stall_early_done pop%0d got %b want 0", i, o_rv[0]); else n_pass++;
        end
        tick();
        n_total++; if (o_rv[0] !== 1'b1) $display("FAIL stall_done got %b want 1", o_rv[0]); else n_pass++;
        n_total++; if (o_max[0] !== exp_max) $display("FAIL stall_max got %0d want %0d", o_max[0], exp_max); else n_pass++;
        n_total++; if (o_mrow[0] !== exp_row) $display("FAIL stall_max_row got %0d want %0d", o_mrow[0], exp_row); else n_pass++;
    endtask

    task automatic test_overflow();
        logic signed [31:0] s [5];
        logic signed [31:0] exp_max;
        logic [15:0]        exp_row;
        exp_max = 32'sh80000000; exp_row = 16'd0;
        for (int i = 0; i < 5; i++) begin
            s[i] = $signed($urandom);
`ifdef SCORE_COLLECTOR_MAX_TRACK_EN
            if (s[i] > exp_max) begin exp_max = s[i]; exp_row = 16'(i); end
`else
            exp_max = s[i]; exp_row = 16'(i);
`endif
        end
        out_ready = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_score = s[i];
            tick();
        end
        in_valid = 1'b0;
        n_total++; if (o_ovf[1] !== 1'b1) $display("FAIL ovf_flag got %b want 1", o_ovf[1]); else n_pass++;
        n_total++; if (o_ov[1] !== 1'b1 || o_row[1] !== 16'd0 || o_sc[1] !== s[0])
            $display("FAIL ovf_head got v=%b r=%0d s=%0d want 1 0 %0d", o_ov[1], o_row[1], o_sc[1], s[0]); else n_pass++;
        n_total++; if (o_fin[1] !== s[4]) $display("FAIL ovf_final got %0d want %0d", o_fin[1], s[4]); else n_pass++;
        n_total++; if (o_max[1] !== exp_max || o_mrow[1] !== exp_row)
            $display("FAIL ovf_max got %0d@%0d want %0d@%0d", o_max[1], o_mrow[1], exp_max, exp_row); else n_pass++;
        n_total++; if (o_busy[1] !== 1'b1) $display("FAIL ovf_busy got %b want 1", o_busy[1]); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_total++; if (o_ov[1] !== 1'b1 || o_row[1] !== 16'd1 || o_sc[1] !== s[1])
            $display("FAIL ovf_second got v=%b r=%0d s=%0d want 1 1 %0d", o_ov[1], o_row[1], o_sc[1], s[1]); else n_pass++;
        tick();
        n_total++; if (o_ov[1] !== 1'b0 || o_rv[1] !== 1'b0) $display("FAIL ovf_empty got v=%b rv=%b want 0 0", o_ov[1], o_rv[1]); else n_pass++;
        tick();
        n_total++; if (o_rv[1] !== 1'b1) $display("FAIL ovf_done got %b want 1", o_rv[1]); else n_pass++;
        repeat (4) tick();
    endtask

    task automatic test_finish();
        logic signed [31:0] s [3];
        for (int i = 0; i < 3; i++) s[i] = $signed($urandom);
        out_ready = 1'b1;
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_score = s[i];
            tick();
        end
        in_valid = 1'b0; in_finish = 1'b1;
        tick();
        in_finish = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_total++; if (o_busy[d] !== 1'b1 || o_rv[d] !== 1'b0)
                $display("FAIL finish_drain dut%0d got busy=%b rv=%b want 1 0", d, o_busy[d], o_rv[d]); else n_pass++;
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            n_total++; if (o_rv[d] !== 1'b1) $display("FAIL finish_done dut%0d got %b want 1", d, o_rv[d]); else n_pass++;
            n_total++; if (o_fin[d] !== s[2]) $display("FAIL finish_final dut%0d got %0d want %0d", d, o_fin[d], s[2]); else n_pass++;
        end
    endtask

    task automatic test_abort();
        logic signed [31:0] x;
        x = $signed($urandom);
        out_ready = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_score = 32'(i + 10);
            tick();
        end
        in_valid = 1'b0;
        n_total++; if (o_ov[0] !== 1'b1) $display("FAIL abort_pre got %b want 1", o_ov[0]); else n_pass++;
        arm = 1'b1; tick(); arm = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_total++; if (o_ov[d] !== 1'b0 || o_busy[d] !== 1'b1)
                $display("FAIL abort_flush dut%0d got v=%b busy=%b want 0 1", d, o_ov[d], o_busy[d]); else n_pass++;
        end
        out_ready = 1'b1; in_valid = 1'b1; in_score = x;
        tick();
        in_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_total++; if (o_ov[d] !== 1'b1 || o_row[d] !== 16'd0 || o_sc[d] !== x)
                $display("FAIL abort_row0 dut%0d got v=%b r=%0d s=%0d want 1 0 %0d", d, o_ov[d], o_row[d], o_sc[d], x); else n_pass++;
        end
        reset = 1'b1; arm = 1'b1;
        tick();
        reset = 1'b0; arm = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_total++; if (o_busy[d] !== 1'b0 || o_max[d] !== 32'sh80000000 || o_ov[d] !== 1'b0 || o_rv[d] !== 1'b0)
                $display("FAIL abort_reset_prio dut%0d got busy=%b max=%h v=%b rv=%b want 0 80000000 0 0",
                         d, o_busy[d], o_max[d], o_ov[d], o_rv[d]); else n_pass++;
        end
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                logic        e_ov;
                logic        e_busy;
                logic [47:0] fr;
                e_ov   = (m_q[d].size() != 0);
                e_busy = (m_st[d] == M_COLLECT) || (m_st[d] == M_DRAIN);
                n_total++; if (o_ov[d] !== e_ov) $display("FAIL rnd_out_valid dut%0d cyc%0d got %b want %b", d, cyc, o_ov[d], e_ov); else n_pass++;
                if (e_ov) begin
                    fr = m_q[d][0];
                    n_total++; if (o_sc[d] !== fr[31:0] || o_row[d] !== fr[47:32])
                        $display("FAIL rnd_out_word dut%0d cyc%0d got %0d@%0d want %0d@%0d", d, cyc, o_sc[d], o_row[d], $signed(fr[31:0]), fr[47:32]); else n_pass++;
                end
                n_total++; if (o_rv[d] !== m_rv[d]) $display("FAIL rnd_result_valid dut%0d cyc%0d got %b want %b", d, cyc, o_rv[d], m_rv[d]); else n_pass++;
                n_total++; if (o_fin[d] !== m_fin[d]) $display("FAIL rnd_final dut%0d cyc%0d got %0d want %0d", d, cyc, o_fin[d], m_fin[d]); else n_pass++;
                n_total++; if (o_max[d] !== m_max[d] || o_mrow[d] !== m_mrow[d])
                    $display("FAIL rnd_max dut%0d cyc%0d got %0d@%0d want %0d@%0d", d, cyc, o_max[d], o_mrow[d], m_max[d], m_mrow[d]); else n_pass++;
                n_total++; if (o_busy[d] !== e_busy) $display("FAIL rnd_busy dut%0d cyc%0d got %b want %b", d, cyc, o_busy[d], e_busy); else n_pass++;
                n_total++; if (o_ovf[d] !== m_ovf[d]) $display("FAIL rnd_overflow dut%0d cyc%0d got %b want %b", d, cyc, o_ovf[d], m_ovf[d]); else n_pass++;
            end
            reset     = ($urandom_range(0, 249) == 0);
            arm       = ($urandom_range(0, 59) == 0) ||
                        ((m_st[0] == M_IDLE || m_st[0] == M_DONE) &&
                         (m_st[1] == M_IDLE || m_st[1] == M_DONE) && ($urandom_range(0, 3) == 0));
            in_valid  = ($urandom_range(0, 2) != 0);
            in_finish = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0:       in_score = 32'sh80000000;
                1:       in_score = $signed($urandom);
                default: in_score = $signed(32'($urandom_range(0, 8))) - 32'sd4;
            endcase
            tick();
        end
        reset = 1'b0; arm = 1'b0; in_valid = 1'b0; in_finish = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_finish();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/score_collector.md
SCORE_COLLECTOR -- requirements
Module: score_collector

Interface
REQ-001 The block SHALL have parameter N, default 8: alignment rows; the block expects N+1 scores, rows 0..N.
REQ-002 The block SHALL have parameter DEPTH, default 16: output FIFO depth, power of 2, minimum 2.
REQ-003 The block SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port arm  input  1  single-cycle pulse that starts a new collection.
REQ-006 The block SHALL have port in_valid  input  1  score strobe (done) from the last-column PE.
REQ-007 The block SHALL have port in_score  input  32  signed score (right) from the last-column PE.
REQ-008 The block SHALL have port in_finish  input  1  finish flag from the last-column PE.
REQ-009 The block SHALL have port out_ready  input  1  downstream accepts the current out word.
REQ-010 The block SHALL have ports out_valid  output  1, out_score  output  32 signed, and out_row  output  16: the per-row score stream.
REQ-011 The block SHALL have ports result_valid  output  1, final_score  output  32 signed, max_score  output  32 signed, and max_row  output  16: the alignment summary.
REQ-012 The block SHALL have ports busy  output  1 (state is COLLECT or DRAIN) and overflow  output  1 (sticky drop flag).

Function
REQ-013 The FSM SHALL have states IDLE, COLLECT, DRAIN and DONE.
REQ-014 In IDLE or DONE, arm SHALL move the FSM to COLLECT and SHALL clear the FIFO, row counter, overflow and result_valid; it SHALL load final_score=0 and max_score=0x80000000.
REQ-015 In IDLE and DONE, in_valid SHALL be ignored.
REQ-016 In COLLECT, each in_valid cycle SHALL push {row_cnt, in_score}, set final_score=in_score and increment row_cnt.
REQ-017 COLLECT SHALL move to DRAIN on the cycle it accepts the row-N score, or on any cycle in_finish=1, whichever comes first.
REQ-018 A push while the FIFO is full with no simultaneous pop SHALL drop the word and set overflow; row_cnt SHALL still increment.
REQ-019 A push while the FIFO is full with a simultaneous pop SHALL be accepted.
REQ-020 The FIFO SHALL be first-word-fall-through; out_valid SHALL equal FIFO non-empty; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-021 Latency SHALL be one cycle: in_valid at cycle t into an empty FIFO gives out_valid=1 at t+1.
REQ-022 out_score and out_row SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 DRAIN SHALL move to DONE when the FIFO is empty; result_valid SHALL be 1 on the first DONE cycle and SHALL hold until the next arm or reset.
REQ-024 arm during COLLECT or DRAIN SHALL abort the run and restart per REQ-014; the FIFO contents SHALL be discarded.
REQ-025 The max comparison SHALL be signed; on equal scores the earliest row SHALL be kept.
REQ-026 row_cnt SHALL be 16 bits and SHALL saturate at 0xFFFF.

Reset
REQ-027 On reset the FSM SHALL enter IDLE and the FIFO SHALL empty.
REQ-028 On reset, out_valid, result_valid, busy and overflow SHALL be 0, and out_score, out_row, final_score and max_row SHALL be 0.
REQ-029 On reset max_score SHALL be 0x80000000.
REQ-030 Reset SHALL take priority over arm and in_valid in the same cycle.

Configuration
REQ-031 Macro SCORE_COLLECTOR_MAX_TRACK_EN SHALL control max tracking.
REQ-032 With SCORE_COLLECTOR_MAX_TRACK_EN defined, max_score and max_row SHALL track the running maximum of the accepted scores and their row, including scores dropped from the FIFO.
REQ-033 Without SCORE_COLLECTOR_MAX_TRACK_EN, max_score SHALL mirror final_score, max_row SHALL equal the last accepted row, and no compare logic SHALL be built.

Structure
REQ-034 Package nw_pkg SHALL hold score_t (signed 32), row_t (16 bit), the collector state enum and SCORE_MIN=0x80000000.
REQ-035 The FIFO SHALL be a sub-module, score_fifo: synchronous FWFT, parameterised by DEPTH and by word type.

Verification
REQ-036 N=3, out_ready=1, arm, then scores -1,-2,0,3 on consecutive cycles -> rows 0..3 out in order with one-cycle latency; result_valid=1, final_score=3, max_score=3, max_row=3.
REQ-037 N=3, out_ready=0, scores 5,5,2,1, then out_ready=1 -> out_score holds 5 while stalled; max_row=0 (tie keeps earliest); DONE only after the fourth pop.
REQ-038 DEPTH=2, out_ready=0, N=4, five scores -> overflow=1, FIFO holds rows 0 and 1, final_score equals the fifth score.
REQ-039 N=8, in_finish=1 after the third score -> DRAIN entered; result_valid=1 once three words are popped; final_score equals the third score.
REQ-040 arm mid-COLLECT after two scores -> out_valid=0 next cycle and the next score is output as row 0; reset asserted concurrently with arm -> state IDLE and max_score=0x80000000.
